// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage
// Full RV32I (optional RV32M) main decoder with illegal-instruction detection,
// load-use interlock, and the ID/EX control register behind a valid/ready
// handshake with flush.
// Ports:
//   clk_dc, rst_dc (async active-low)
//   in_valid_dc/in_ready_dc, instr_dc, pc_dc      : decode-side handshake
//   flush_dc                                       : kill held entry, refuse input
//   out_valid_dc/out_ready_dc                      : execute-side handshake
//   out_pc_dc, out_rd/rs1/rs2_dc, out_funct3_dc,
//   out_funct7b5_dc                                : pass-through fields
//   pc_src, result_src, alu_op, imm_src, alu_src, reg_write, mem_write,
//   auipc_sel, lui_sel, branch_op, jump_op, mul_op, illegal (_dc) : controls
module decode_ctrl_stage #(
  parameter int unsigned XLEN           = 32,
  parameter bit          M_EXT          = 1'b0,
  parameter bit          LOAD_USE_STALL = 1'b1
) (
  input  logic            clk_dc,
  input  logic            rst_dc,
  input  logic            in_valid_dc,
  output logic            in_ready_dc,
  input  logic [31:0]     instr_dc,
  input  logic [XLEN-1:0] pc_dc,
  input  logic            flush_dc,
  output logic            out_valid_dc,
  input  logic            out_ready_dc,
  output logic [XLEN-1:0] out_pc_dc,
  output logic [4:0]      out_rd_dc,
  output logic [4:0]      out_rs1_dc,
  output logic [4:0]      out_rs2_dc,
  output logic [2:0]      out_funct3_dc,
  output logic            out_funct7b5_dc,
  output logic [1:0]      pc_src_dc,
  output logic [1:0]      result_src_dc,
  output logic [1:0]      alu_op_dc,
  output logic [2:0]      imm_src_dc,
  output logic            alu_src_dc,
  output logic            reg_write_dc,
  output logic            mem_write_dc,
  output logic            auipc_sel_dc,
  output logic            lui_sel_dc,
  output logic            branch_op_dc,
  output logic            jump_op_dc,
  output logic            mul_op_dc,
  output logic            illegal_dc
);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_BRANCH = 7'b1100011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111
  } opcode_e;

  opcode_e    opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = opcode_e'(instr_dc[6:0]);
  assign f3  = instr_dc[14:12];
  assign f7  = instr_dc[31:25];

  logic [2:0] d_imm_src;
  logic [1:0] d_pc_src, d_result_src, d_alu_op;
  logic       d_alu_src, d_reg_write, d_mem_write, d_auipc, d_lui;
  logic       d_branch, d_jump, d_mul, d_illegal;
  logic       uses_rs1, uses_rs2;

  always_comb begin
    d_imm_src    = '0;
    d_pc_src     = '0;
    d_result_src = '0;
    d_alu_op     = '0;
    d_alu_src    = 1'b0;
    d_reg_write  = 1'b0;
    d_mem_write  = 1'b0;
    d_auipc      = 1'b0;
    d_lui        = 1'b0;
    d_branch     = 1'b0;
    d_jump       = 1'b0;
    d_mul        = 1'b0;
    d_illegal    = 1'b0;
    uses_rs1     = 1'b1;
    uses_rs2     = 1'b0;
    case (opc)
      OPC_STORE: begin
        d_imm_src = 3'b001; d_mem_write = 1'b1; d_alu_src = 1'b1;
        d_result_src = 2'b01; uses_rs2 = 1'b1;
        if (f3 >= 3'b011) d_illegal = 1'b1;
      end
      OPC_LOAD: begin
        d_reg_write = 1'b1; d_alu_src = 1'b1; d_result_src = 2'b01;
        if (f3 == 3'b011 || f3[2:1] == 2'b11) d_illegal = 1'b1;
      end
      OPC_OPIMM: begin
        d_reg_write = 1'b1; d_alu_src = 1'b1; d_alu_op = 2'b10;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          d_imm_src = 3'b101;
          if (!(f7 == 7'b0000000 || (f3 == 3'b101 && f7 == 7'b0100000)))
            d_illegal = 1'b1;
        end
      end
      OPC_OP: begin
        d_reg_write = 1'b1; d_alu_op = 2'b10; uses_rs2 = 1'b1;
        if (f7 == 7'b0000000) begin
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
        end else if (f7 == 7'b0000001 && M_EXT) begin
          d_mul = 1'b1;
        end else begin
          d_illegal = 1'b1;
        end
      end
      OPC_BRANCH: begin
        d_imm_src = 3'b010; d_result_src = 2'b10; d_alu_op = 2'b11;
        d_branch = 1'b1; uses_rs2 = 1'b1;
        if (f3[2:1] == 2'b01) d_illegal = 1'b1;
      end
      OPC_LUI: begin
        d_imm_src = 3'b011; d_reg_write = 1'b1; d_alu_src = 1'b1;
        d_lui = 1'b1; uses_rs1 = 1'b0;
      end
      OPC_AUIPC: begin
        d_imm_src = 3'b011; d_reg_write = 1'b1; d_alu_src = 1'b1;
        d_auipc = 1'b1; uses_rs1 = 1'b0;
      end
      OPC_JAL: begin
        d_imm_src = 3'b100; d_reg_write = 1'b1; d_alu_src = 1'b1;
        d_result_src = 2'b10; d_pc_src = 2'b10; d_jump = 1'b1; uses_rs1 = 1'b0;
      end
      OPC_JALR: begin
        d_reg_write = 1'b1; d_alu_src = 1'b1; d_result_src = 2'b10;
        d_pc_src = 2'b01; d_jump = 1'b1;
        if (f3 != 3'b000) d_illegal = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
    if (instr_dc[1:0] != 2'b11) d_illegal = 1'b1;
    // Illegal entries carry only the illegal flag; every other control is zero.
    if (d_illegal) begin
      d_imm_src    = '0;
      d_pc_src     = '0;
      d_result_src = '0;
      d_alu_op     = '0;
      d_alu_src    = 1'b0;
      d_reg_write  = 1'b0;
      d_mem_write  = 1'b0;
      d_auipc      = 1'b0;
      d_lui        = 1'b0;
      d_branch     = 1'b0;
      d_jump       = 1'b0;
      d_mul        = 1'b0;
    end
  end

  // A legal load is the only entry with result_src=01 and reg_write set.
  logic held_load, stall, accept;
  assign held_load = out_valid_dc & (result_src_dc == 2'b01) & reg_write_dc & ~mem_write_dc;
  assign stall = LOAD_USE_STALL && held_load && (out_rd_dc != 5'd0) &&
                 ((uses_rs1 && instr_dc[19:15] == out_rd_dc) ||
                  (uses_rs2 && instr_dc[24:20] == out_rd_dc));

  assign in_ready_dc = rst_dc & ~flush_dc & ~stall & (~out_valid_dc | out_ready_dc);
  assign accept      = in_valid_dc & in_ready_dc;

  always_ff @(posedge clk_dc or negedge rst_dc) begin
    if (!rst_dc) begin
      out_valid_dc    <= 1'b0;
      out_pc_dc       <= '0;
      out_rd_dc       <= '0;
      out_rs1_dc      <= '0;
      out_rs2_dc      <= '0;
      out_funct3_dc   <= '0;
      out_funct7b5_dc <= 1'b0;
      pc_src_dc       <= '0;
      result_src_dc   <= '0;
      alu_op_dc       <= '0;
      imm_src_dc      <= '0;
      alu_src_dc      <= 1'b0;
      reg_write_dc    <= 1'b0;
      mem_write_dc    <= 1'b0;
      auipc_sel_dc    <= 1'b0;
      lui_sel_dc      <= 1'b0;
      branch_op_dc    <= 1'b0;
      jump_op_dc      <= 1'b0;
      mul_op_dc       <= 1'b0;
      illegal_dc      <= 1'b0;
    end else if (accept) begin
      out_valid_dc    <= 1'b1;
      out_pc_dc       <= pc_dc;
      out_rd_dc       <= instr_dc[11:7];
      out_rs1_dc      <= instr_dc[19:15];
      out_rs2_dc      <= instr_dc[24:20];
      out_funct3_dc   <= f3;
      out_funct7b5_dc <= instr_dc[30];
      pc_src_dc       <= d_pc_src;
      result_src_dc   <= d_result_src;
      alu_op_dc       <= d_alu_op;
      imm_src_dc      <= d_imm_src;
      alu_src_dc      <= d_alu_src;
      reg_write_dc    <= d_reg_write;
      mem_write_dc    <= d_mem_write;
      auipc_sel_dc    <= d_auipc;
      lui_sel_dc      <= d_lui;
      branch_op_dc    <= d_branch;
      jump_op_dc      <= d_jump;
      mul_op_dc       <= d_mul;
      illegal_dc      <= d_illegal;
    end else if (flush_dc || !out_valid_dc || out_ready_dc) begin
      // accept already excludes flush, so flush and drain share this clear.
      out_valid_dc <= 1'b0;
      reg_write_dc <= 1'b0;
      mem_write_dc <= 1'b0;
      branch_op_dc <= 1'b0;
      jump_op_dc   <= 1'b0;
      mul_op_dc    <= 1'b0;
      pc_src_dc    <= '0;
      illegal_dc   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Self-checking bench for decode_ctrl_stage: decode table, hand-written
// handshake sequences, and randomized traffic against a behavioural model.
// Two instances share stimulus: A (M_EXT=0, interlock on), B (M_EXT=1, interlock off).
module tb_decode_ctrl_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [1:0]  pc_src, result_src, alu_op;
    logic [2:0]  imm_src;
    logic        alu_src, reg_write, mem_write, auipc, lui, branch, jump, mul, illegal;
  } obs_t;

  typedef struct {
    logic [31:0] instr;
    logic [12:0] ctrl;   // {imm_src, reg_write, mem_write, alu_src, result_src, pc_src, alu_op}
    logic [5:0]  flags;  // {lui, auipc, branch, jump, mul, illegal}
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_dc = 1'b1;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0, pc = '0;

  logic a_in_ready, a_out_valid, a_f7b5, a_alu_src, a_reg_write, a_mem_write;
  logic a_auipc, a_lui, a_branch, a_jump, a_mul, a_illegal;
  logic [31:0] a_pc;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [2:0]  a_f3, a_imm_src;
  logic [1:0]  a_pc_src, a_result_src, a_alu_op;
  logic b_in_ready, b_out_valid, b_f7b5, b_alu_src, b_reg_write, b_mem_write;
  logic b_auipc, b_lui, b_branch, b_jump, b_mul, b_illegal;
  logic [31:0] b_pc;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_f3, b_imm_src;
  logic [1:0]  b_pc_src, b_result_src, b_alu_op;

  obs_t a_obs, b_obs;
  assign a_obs = {a_out_valid, a_pc, a_rd, a_rs1, a_rs2, a_f3, a_f7b5, a_pc_src, a_result_src,
                  a_alu_op, a_imm_src, a_alu_src, a_reg_write, a_mem_write, a_auipc, a_lui,
                  a_branch, a_jump, a_mul, a_illegal};
  assign b_obs = {b_out_valid, b_pc, b_rd, b_rs1, b_rs2, b_f3, b_f7b5, b_pc_src, b_result_src,
                  b_alu_op, b_imm_src, b_alu_src, b_reg_write, b_mem_write, b_auipc, b_lui,
                  b_branch, b_jump, b_mul, b_illegal};

  decode_ctrl_stage #(.XLEN(32), .M_EXT(1'b0), .LOAD_USE_STALL(1'b1)) dut_a (
    .clk_dc(clk), .rst_dc(rst_dc), .in_valid_dc(in_valid), .in_ready_dc(a_in_ready),
    .instr_dc(instr), .pc_dc(pc), .flush_dc(flush), .out_valid_dc(a_out_valid),
    .out_ready_dc(out_ready), .out_pc_dc(a_pc), .out_rd_dc(a_rd), .out_rs1_dc(a_rs1),
    .out_rs2_dc(a_rs2), .out_funct3_dc(a_f3), .out_funct7b5_dc(a_f7b5),
    .pc_src_dc(a_pc_src), .result_src_dc(a_result_src), .alu_op_dc(a_alu_op),
    .imm_src_dc(a_imm_src), .alu_src_dc(a_alu_src), .reg_write_dc(a_reg_write),
    .mem_write_dc(a_mem_write), .auipc_sel_dc(a_auipc), .lui_sel_dc(a_lui),
    .branch_op_dc(a_branch), .jump_op_dc(a_jump), .mul_op_dc(a_mul), .illegal_dc(a_illegal));

  decode_ctrl_stage #(.XLEN(32), .M_EXT(1'b1), .LOAD_USE_STALL(1'b0)) dut_b (
    .clk_dc(clk), .rst_dc(rst_dc), .in_valid_dc(in_valid), .in_ready_dc(b_in_ready),
    .instr_dc(instr), .pc_dc(pc), .flush_dc(flush), .out_valid_dc(b_out_valid),
    .out_ready_dc(out_ready), .out_pc_dc(b_pc), .out_rd_dc(b_rd), .out_rs1_dc(b_rs1),
    .out_rs2_dc(b_rs2), .out_funct3_dc(b_f3), .out_funct7b5_dc(b_f7b5),
    .pc_src_dc(b_pc_src), .result_src_dc(b_result_src), .alu_op_dc(b_alu_op),
    .imm_src_dc(b_imm_src), .alu_src_dc(b_alu_src), .reg_write_dc(b_reg_write),
    .mem_write_dc(b_mem_write), .auipc_sel_dc(b_auipc), .lui_sel_dc(b_lui),
    .branch_op_dc(b_branch), .jump_op_dc(b_jump), .mul_op_dc(b_mul), .illegal_dc(b_illegal));

  always #5 clk = ~clk;

  int passed = 0, total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OPIMM = 7'b0010011,
                         OP = 7'b0110011, BRANCH = 7'b1100011, LUI = 7'b0110111,
                         AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;

  function automatic bit is_legal(input logic [31:0] i, input bit mext);
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    case (i[6:0])
      OP:     return f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (f7 == 7'h01 && mext);
      OPIMM:  begin
                if (f3 == 3'd1) return f7 == 7'h00;
                if (f3 == 3'd5) return f7 == 7'h00 || f7 == 7'h20;
                return 1'b1;
              end
      JALR:   return f3 == 3'd0;
      BRANCH: return !(f3 == 3'd2 || f3 == 3'd3);
      LOAD:   return !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      STORE:  return f3 < 3'd3;
      LUI, AUIPC, JAL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic obs_t ref_accept(input logic [31:0] i, input logic [31:0] p, input bit mext);
    obs_t o = '0;
    logic [12:0] row = '0;
    o.valid = 1'b1; o.pc = p; o.rd = i[11:7]; o.rs1 = i[19:15]; o.rs2 = i[24:20];
    o.f3 = i[14:12]; o.f7b5 = i[30];
    if (!is_legal(i, mext)) begin
      o.illegal = 1'b1;
      return o;
    end
    case (i[6:0])
      STORE:       row = 13'b001_0_1_1_01_00_00;
      LOAD:        row = 13'b000_1_0_1_01_00_00;
      OPIMM:       row = (i[14:12] == 3'd1 || i[14:12] == 3'd5) ? 13'b101_1_0_1_00_00_10
                                                                 : 13'b000_1_0_1_00_00_10;
      OP:          row = 13'b000_1_0_0_00_00_10;
      BRANCH:      row = 13'b010_0_0_0_10_00_11;
      LUI, AUIPC:  row = 13'b011_1_0_1_00_00_00;
      JAL:         row = 13'b100_1_0_1_10_10_00;
      default:     row = 13'b000_1_0_1_10_01_00;  // jalr
    endcase
    {o.imm_src, o.reg_write, o.mem_write, o.alu_src, o.result_src, o.pc_src, o.alu_op} = row;
    o.branch = (i[6:0] == BRANCH);
    o.jump   = (i[6:0] == JAL) || (i[6:0] == JALR);
    o.lui    = (i[6:0] == LUI);
    o.auipc  = (i[6:0] == AUIPC);
    o.mul    = (i[6:0] == OP) && (i[31:25] == 7'h01);
    return o;
  endfunction

  function automatic obs_t ref_clear(input obs_t o);
    obs_t r = o;
    r.valid = 0; r.reg_write = 0; r.mem_write = 0; r.branch = 0; r.jump = 0;
    r.mul = 0; r.pc_src = '0; r.illegal = 0;
    return r;
  endfunction

  function automatic bit ref_ready(input obs_t m, input logic [31:0] held, input bit lus,
                                   input logic [31:0] inc, input logic fl, input logic ordy);
    bit r1, r2, stall;
    r1 = !(inc[6:0] == LUI || inc[6:0] == AUIPC || inc[6:0] == JAL);
    r2 = (inc[6:0] == OP || inc[6:0] == BRANCH || inc[6:0] == STORE);
    stall = lus && m.valid && !m.illegal && held[6:0] == LOAD && held[11:7] != 5'd0 &&
            ((r1 && inc[19:15] == held[11:7]) || (r2 && inc[24:20] == held[11:7]));
    return !fl && !stall && (!m.valid || ordy);
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0] ops [9];
    int unsigned k;
    logic [6:0] f7;
    ops = '{LOAD, STORE, OPIMM, OP, BRANCH, LUI, AUIPC, JAL, JALR};
    k = $urandom_range(9);
    if (k == 9) return $urandom;
    case ($urandom_range(3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom_range(3)), 5'($urandom_range(3)), 3'($urandom_range(7)),
            5'($urandom_range(3)), ops[k]};
  endfunction

  task automatic do_reset();
    in_valid = 0; flush = 0; out_ready = 0;
    rst_dc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_dc = 1;
  endtask

  vec_t tbl [20];
  obs_t ma, mb;
  logic [31:0] mia, mib;
  bit ra, rb;

  initial begin
    tbl = '{
      '{32'h00500093, 13'b000_1_0_1_00_00_10, 6'b000000},  // addi
      '{32'h00209093, 13'b101_1_0_1_00_00_10, 6'b000000},  // slli
      '{32'h4000D093, 13'b101_1_0_1_00_00_10, 6'b000000},  // srai
      '{32'h00012283, 13'b000_1_0_1_01_00_00, 6'b000000},  // lw
      '{32'h00112023, 13'b001_0_1_1_01_00_00, 6'b000000},  // sw
      '{32'h00208463, 13'b010_0_0_0_10_00_11, 6'b001000},  // beq
      '{32'h123450B7, 13'b011_1_0_1_00_00_00, 6'b100000},  // lui
      '{32'h00001097, 13'b011_1_0_1_00_00_00, 6'b010000},  // auipc
      '{32'h0000006F, 13'b100_1_0_1_10_10_00, 6'b000100},  // jal
      '{32'h000080E7, 13'b000_1_0_1_10_01_00, 6'b000100},  // jalr
      '{32'h40208033, 13'b000_1_0_0_00_00_10, 6'b000000},  // sub
      '{32'h022081B3, 13'b0, 6'b000001},                  // mul without M
      '{32'hFFFFFFFF, 13'b0, 6'b000001},
      '{32'h00003003, 13'b0, 6'b000001},                  // ld
      '{32'h40209033, 13'b0, 6'b000001},                  // sll with funct7 0100000
      '{32'h00001067, 13'b0, 6'b000001},                  // jalr funct3 001
      '{32'h00002063, 13'b0, 6'b000001},                  // branch funct3 010
      '{32'h00003023, 13'b0, 6'b000001},                  // store funct3 011
      '{32'h40001093, 13'b0, 6'b000001},                  // slli with funct7 0100000
      '{32'h00000073, 13'b0, 6'b000001}                   // system opcode
    };

    // Reset state
    #1 rst_dc = 0;
    #1;
    chk("reset_outputs_a", a_obs, '0);
    chk("reset_outputs_b", b_obs, '0);
    chk("reset_in_ready", a_in_ready, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_dc = 1;
    #1 chk("ready_after_release", a_in_ready, 1'b1);

    // Reset mid-transfer while an entry is held
    @(negedge clk);
    in_valid = 1; instr = 32'h00500093; pc = 32'h100; out_ready = 0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    chk("held_valid_before_reset", a_out_valid, 1'b1);
    #2 rst_dc = 0;
    #1;
    chk("midreset_outputs", a_obs, '0);
    chk("midreset_in_ready", a_in_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("reset_held_ready_low", a_in_ready, 1'b0);
    rst_dc = 1; out_ready = 1;
    #1 chk("ready_after_midreset", a_in_ready, 1'b1);

    // Decode table
    foreach (tbl[k]) begin
      @(negedge clk);
      in_valid = 1; instr = tbl[k].instr; pc = $urandom; out_ready = 1;
      #1 chk("tbl_in_ready", a_in_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
      chk($sformatf("tbl%0d_valid", k), a_out_valid, 1'b1);
      chk($sformatf("tbl%0d_ctrl", k),
          {a_imm_src, a_reg_write, a_mem_write, a_alu_src, a_result_src, a_pc_src, a_alu_op},
          tbl[k].ctrl);
      chk($sformatf("tbl%0d_flags", k), {a_lui, a_auipc, a_branch, a_jump, a_mul, a_illegal},
          tbl[k].flags);
      chk($sformatf("tbl%0d_fields", k), {a_pc, a_rd, a_rs1, a_rs2, a_f3, a_f7b5},
          {pc, instr[11:7], instr[19:15], instr[24:20], instr[14:12], instr[30]});
      chk($sformatf("tbl%0d_b_model", k), b_obs, ref_accept(instr, pc, 1'b1));
      if (tbl[k].instr == 32'h022081B3)
        chk("mul_with_m_ext", {b_mul, b_reg_write, b_alu_op, b_illegal}, 5'b1_1_10_0);
    end

    // Load-use: lw x5 then add x6,x5,x1
    @(negedge clk);
    in_valid = 1; instr = 32'h00012283; out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("lu_lw_out", {a_out_valid, a_rd}, {1'b1, 5'd5});
    instr = 32'h00128333;
    #1 chk("lu_stall_ready", a_in_ready, 1'b0);
    chk("lu_nostall_ready_b", b_in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("lu_bubble", a_out_valid, 1'b0);
    chk("lu_b_no_bubble", {b_out_valid, b_rd}, {1'b1, 5'd6});
    #1 chk("lu_ready_after_bubble", a_in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    chk("lu_add_out", {a_out_valid, a_rd, a_reg_write}, {1'b1, 5'd6, 1'b1});

    // Load to x0 never interlocks
    @(negedge clk);
    in_valid = 1; instr = 32'h00012003;
    @(posedge clk);
    @(negedge clk);
    instr = 32'h00100333;
    #1 chk("lu_x0_ready", a_in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    chk("lu_x0_out", {a_out_valid, a_rd}, {1'b1, 5'd6});

    // jal held under backpressure, then flushed with input pending
    @(negedge clk);
    in_valid = 1; instr = 32'h0000006F; pc = 32'h200; out_ready = 0;
    @(posedge clk);
    @(negedge clk);
    instr = 32'h00500093;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold%0d_outs", c),
          {a_out_valid, a_pc_src, a_jump, a_rd, a_imm_src, a_pc, a_reg_write},
          {1'b1, 2'b10, 1'b1, 5'd0, 3'b100, 32'h200, 1'b1});
      chk($sformatf("hold%0d_ready", c), a_in_ready, 1'b0);
      @(negedge clk);
    end
    flush = 1;
    #1 chk("flush_ready", a_in_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    flush = 0; in_valid = 0;
    chk("flush_clears", {a_out_valid, a_jump, a_pc_src, a_reg_write}, 5'b0);
    chk("flush_no_accept", {a_rd, a_imm_src, a_alu_src, a_pc}, {5'd0, 3'b100, 1'b1, 32'h200});

    // Randomized traffic against the model
    do_reset();
    ma = '0; mb = '0; mia = '0; mib = '0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      chk("rand_out_a", a_obs, ma);
      chk("rand_out_b", b_obs, mb);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(9) < 7);
      flush     = ($urandom_range(19) == 0);
      instr     = gen_instr();
      pc        = $urandom;
      #1;
      ra = ref_ready(ma, mia, 1'b1, instr, flush, out_ready);
      rb = ref_ready(mb, mib, 1'b0, instr, flush, out_ready);
      chk("rand_ready_a", a_in_ready, ra);
      chk("rand_ready_b", b_in_ready, rb);
      @(posedge clk);
      if (flush) ma = ref_clear(ma);
      else if (in_valid && ra) begin ma = ref_accept(instr, pc, 1'b0); mia = instr; end
      else if (!(ma.valid && !out_ready)) ma = ref_clear(ma);
      if (flush) mb = ref_clear(mb);
      else if (in_valid && rb) begin mb = ref_accept(instr, pc, 1'b1); mib = instr; end
      else if (!(mb.valid && !out_ready)) mb = ref_clear(mb);
    end
    @(negedge clk);
    chk("rand_final_a", a_obs, ma);
    chk("rand_final_b", b_obs, mb);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_stage.md
# decode_ctrl_stage

Parametrised successor to the core's combinational main decoder. It decodes a full 32-bit RV32I instruction (RV32M optional) into the same control-signal encoding, adds illegal-instruction detection and a load-use interlock, and registers the result as the ID/EX control register with a valid/ready handshake and flush. It sits between the fetch/decode boundary and the execute stage.

## Interface
- XLEN, 32, width of the PC carried alongside the instruction
- M_EXT, 0, 1 = decode OP with funct7 0000001 as a multiply/divide op; 0 = such encodings are illegal
- LOAD_USE_STALL, 1, 1 = internal load-use interlock enabled; 0 = stall term tied off
- clk_dc  input  1  clock, rising edge
- rst_dc  input  1  reset, asynchronous, active-low
- in_valid_dc  input  1  instr_dc/pc_dc valid
- in_ready_dc  output  1  stage accepts input this cycle
- instr_dc  input  32  instruction
- pc_dc  input  XLEN  instruction PC
- flush_dc  input  1  kill held entry and refuse input
- out_valid_dc  output  1  registered entry valid
- out_ready_dc  input  1  execute consumes entry
- out_pc_dc  output  XLEN; out_rd_dc, out_rs1_dc, out_rs2_dc  output  5 each; out_funct3_dc  output  3; out_funct7b5_dc  output  1 (instr[30])
- pc_src, result_src, alu_op  output  2 each; imm_src  output  3; alu_src, reg_write, mem_write, auipc_sel, lui_sel, branch_op, jump_op, mul_op, illegal  output  1 each (all registered, suffix _dc)

## Operation
- Decode (opcode: imm_src/reg_write/mem_write/alu_src/result_src/pc_src/alu_op):
  - 0100011 store: 001/0/1/1/01/00/00
  - 0000011 load: 000/1/0/1/01/00/00
  - 0010011 op-imm: 000 (101 if funct3 001 or 101)/1/0/1/00/00/10
  - 0110011 op: 000/1/0/0/00/00/10; mul_op=1 when M_EXT=1 and funct7=0000001
  - 1100011 branch: 010/0/0/0/10/00/11; branch_op=1
  - 0110111 lui: 011/1/0/1/00/00/00; lui_sel=1
  - 0010111 auipc: 011/1/0/1/00/00/00; auipc_sel=1
  - 1101111 jal: 100/1/0/1/10/10/00; jump_op=1
  - 1100111 jalr: 000/1/0/1/10/01/00; jump_op=1
- illegal=1 when: instr[1:0]≠11; opcode outside the list; op funct7 not 0000000, not 0100000 with funct3 000/101, not 0000001 with M_EXT=1; op-imm shift with funct7 not 0000000 (or 0100000 for funct3 101); jalr funct3≠000; branch funct3 010/011; load funct3 011/110/111; store funct3 ≥011.
- Illegal entries are still delivered valid, with illegal=1 and all other control outputs 0.
- Register fields rd=instr[11:7], rs1=[19:15], rs2=[24:20] pass through unconditionally.
- Load-use stall: held entry valid, load, rd≠0, and incoming instruction reads that rd. rs1 is read by all except lui/auipc/jal; rs2 only by op/branch/store. Stall forces in_ready=0.
- in_ready = rst_dc & !flush_dc & !stall & (!out_valid | out_ready).
- Accept (in_valid & in_ready): entry loads decoded values; out_valid=1.
- Drain without accept: out_valid=0, and reg_write, mem_write, branch_op, jump_op, mul_op, pc_src, illegal cleared to 0. Other fields hold.
- Backpressure (out_valid & !out_ready): all outputs held stable.
- flush_dc: next edge out_valid=0 with the same clears; no accept. Priority over accept and drain.

## Timing
- Reset (rst_dc=0, any time including mid-handshake): all registered outputs 0 immediately; in_ready=0 while asserted; in_ready=1 on the first cycle after release.
- Latency: accepted at edge N, visible at out_* after edge N.
- Throughput: 1/cycle with out_ready=1.
- Load-use: exactly one bubble cycle (out_valid=0) between the load and its dependent.
- Decode and stall are combinational from instr_dc and the held entry; no output is combinational from inputs except in_ready.

## Test plan
- Reset mid-transfer with out_valid=1, then release → all outputs 0, in_ready 0 during reset, 1 after.
- 0x00500093 (addi x1,x0,5), out_ready=1 → next cycle out_valid=1, rd=1, rs1=0, alu_src=1, alu_op=10, reg_write=1, imm_src=000; 0x00209093 (slli) → imm_src=101.
- 0x00012283 (lw x5,0(x2)) then 0x00128333 (add x6,x5,x1) back-to-back → in_ready low 1 cycle, one out_valid=0 cycle, add out 2 cycles after lw; with rd=x0 or LOAD_USE_STALL=0 → no bubble.
- 0x022081B3 (mul x3,x1,x2): M_EXT=0 → illegal=1, reg_write=0. M_EXT=1 → mul_op=1, reg_write=1, alu_op=10.
- 0x0000006F (jal x0,0) held with out_ready=0 for 3 cycles → outputs stable, pc_src=10, in_ready=0; then flush_dc=1 → out_valid=0, jump_op=0, pending input not accepted.
- 0xFFFFFFFF and 0x00003003 (ld) → illegal=1, out_valid=1, all write enables 0.
